// File: rtl/axis_pipe_n.sv
// AXI4-Stream register pipeline: STAGES chained skid-buffer slices with registered ready,
// optional output byte swap, and occupancy / delivered-packet status counters.
module axis_pipe_n #(
  parameter int unsigned AXIS_WIDTH = 32,
  parameter int unsigned STAGES     = 2,
  parameter bit          BYTE_SWAP  = 1'b0,
  localparam int unsigned OccW      = $clog2(2 * STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_axis_tvalid,
  input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [OccW-1:0]       occupancy,
  output logic [15:0]           pkt_count
);

  localparam int unsigned NumBytes = AXIS_WIDTH / 8;

  // Index k is the input side of stage k; index STAGES is the output side.
  logic [STAGES:0]     v_chain;
  logic [STAGES:0]     l_chain;
  logic [STAGES:0]     rdy_chain;
  logic [AXIS_WIDTH-1:0] d_chain [STAGES+1];

  assign v_chain[0]        = s_axis_tvalid;
  assign d_chain[0]        = s_axis_tdata;
  assign l_chain[0]        = s_axis_tlast;
  assign rdy_chain[STAGES] = m_axis_tready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                  main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic                  main_l_q, main_l_d, skid_l_q, skid_l_d;
    logic [AXIS_WIDTH-1:0] main_d_q, main_d_d, skid_d_q, skid_d_d;
    logic                  rdy_q;
    logic                  in_fire, out_fire;

    assign in_fire  = v_chain[k] & rdy_q;
    assign out_fire = main_v_q & rdy_chain[k+1];

    always_comb begin
      main_v_d = main_v_q;
      main_d_d = main_d_q;
      main_l_d = main_l_q;
      skid_v_d = skid_v_q;
      skid_d_d = skid_d_q;
      skid_l_d = skid_l_q;
      if (!main_v_q) begin
        if (in_fire) begin
          main_v_d = 1'b1;
          main_d_d = d_chain[k];
          main_l_d = l_chain[k];
        end
      end else if (skid_v_q) begin
        if (out_fire) begin
          main_d_d = skid_d_q;
          main_l_d = skid_l_q;
          skid_v_d = 1'b0;
        end
      end else if (out_fire && in_fire) begin
        main_d_d = d_chain[k];
        main_l_d = l_chain[k];
      end else if (out_fire) begin
        main_v_d = 1'b0;
      end else if (in_fire) begin
        skid_v_d = 1'b1;
        skid_d_d = d_chain[k];
        skid_l_d = l_chain[k];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        main_v_q <= 1'b0;
        main_d_q <= '0;
        main_l_q <= 1'b0;
        skid_v_q <= 1'b0;
        skid_d_q <= '0;
        skid_l_q <= 1'b0;
        rdy_q    <= 1'b0;
      end else begin
        main_v_q <= main_v_d;
        main_d_q <= main_d_d;
        main_l_q <= main_l_d;
        skid_v_q <= skid_v_d;
        skid_d_q <= skid_d_d;
        skid_l_q <= skid_l_d;
        // Ready tracks the skid's next state so a full slice never accepts an extra beat.
        rdy_q    <= ~skid_v_d;
      end
    end

    assign v_chain[k+1] = main_v_q;
    assign d_chain[k+1] = main_d_q;
    assign l_chain[k+1] = main_l_q;
    assign rdy_chain[k] = rdy_q;
  end

  assign s_axis_tready = rdy_chain[0];
  assign m_axis_tvalid = v_chain[STAGES];
  assign m_axis_tlast  = l_chain[STAGES];

  for (genvar b = 0; b < NumBytes; b++) begin : g_bytes
    if (BYTE_SWAP) begin : g_swap
      assign m_axis_tdata[8*b +: 8] = d_chain[STAGES][8*(NumBytes-1-b) +: 8];
    end else begin : g_pass
      assign m_axis_tdata[8*b +: 8] = d_chain[STAGES][8*b +: 8];
    end
  end

  logic            s_fire, m_fire;
  logic [OccW-1:0] occ_q, occ_d;
  logic [15:0]     pkt_q, pkt_d;

  assign s_fire = s_axis_tvalid & rdy_chain[0];
  assign m_fire = v_chain[STAGES] & m_axis_tready;

  always_comb begin
    occ_d = occ_q;
    if (s_fire && !m_fire) begin
      occ_d = occ_q + OccW'(1);
    end else if (!s_fire && m_fire) begin
      occ_d = occ_q - OccW'(1);
    end
    pkt_d = pkt_q;
    if (m_fire && l_chain[STAGES]) begin
      pkt_d = pkt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
      pkt_q <= '0;
    end else begin
      occ_q <= occ_d;
      pkt_q <= pkt_d;
    end
  end

  assign occupancy = occ_q;
  assign pkt_count = pkt_q;

endmodule

// File: tb/tb_axis_pipe_n.sv
// Bench for axis_pipe_n (32-bit, 2 stages, byte swap on): vector table, directed corner
// sequences and a random valid/ready run, all checked against a scoreboard queue.
module tb_axis_pipe_n;

  localparam int unsigned W      = 32;
  localparam int unsigned STAGES = 2;
  localparam int unsigned OW     = $clog2(2 * STAGES + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic [OW-1:0] occupancy;
  logic [15:0]   pkt_count;

  axis_pipe_n #(
    .AXIS_WIDTH(W),
    .STAGES    (STAGES),
    .BYTE_SWAP (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .occupancy    (occupancy),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       sb_q[$];
  logic [15:0] exp_pkt = '0;
  logic        started = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      beat_t got;
      check("occupancy", 32'(occupancy), 32'(sb_q.size()));
      check("pkt_count", 32'(pkt_count), 32'(exp_pkt));
      if (prev_stall) begin
        check("hold_valid", 32'(m_axis_tvalid), 32'd1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_last", 32'(m_axis_tlast), 32'(prev_last));
      end
      if (reset) begin
        sb_q.delete();
        exp_pkt    = '0;
        prev_stall = 1'b0;
      end else begin
        if (m_axis_tvalid && m_axis_tready) begin
          check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check("out_data", m_axis_tdata, got.d);
            check("out_last", 32'(m_axis_tlast), 32'(got.l));
          end
          if (m_axis_tlast) exp_pkt = exp_pkt + 16'd1;
        end
        if (s_axis_tvalid && s_axis_tready) sb_q.push_back('{d: bswap(s_axis_tdata), l: s_axis_tlast});
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  task automatic do_reset();
    reset         = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int guard = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    while (!s_axis_tready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("send_timeout", 32'(guard < 200), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    while ((occupancy != 0 || m_axis_tvalid) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_timeout", 32'(guard < 100), 32'd1);
  endtask

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic [31:0] e_md;
    logic        e_ml;
    logic [2:0]  e_occ;
    logic [15:0] e_pkt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int acc;
    int waited;
    int sent;
    logic acc_now;

    // Inputs of each row and the outputs expected during that same cycle.
    tbl[0]  = '{1'b1, 32'h11223344, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 3'd0, 16'd0};
    tbl[1]  = '{1'b1, 32'h11223344, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 16'd0};
    tbl[2]  = '{1'b1, 32'hAABBCCDD, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd1, 16'd0};
    tbl[3]  = '{1'b1, 32'h01020304, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211, 1'b1, 3'd2, 16'd0};
    tbl[4]  = '{1'b1, 32'h05060708, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44332211, 1'b1, 3'd3, 16'd0};
    tbl[5]  = '{1'b1, 32'h0A0B0C0D, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211, 1'b1, 3'd4, 16'd0};
    tbl[6]  = '{1'b1, 32'h0A0B0C0D, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44332211, 1'b1, 3'd4, 16'd0};
    tbl[7]  = '{1'b1, 32'h0A0B0C0D, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDDCCBBAA, 1'b0, 3'd3, 16'd1};
    tbl[8]  = '{1'b1, 32'h0A0B0C0D, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 1'b0, 3'd2, 16'd1};
    tbl[9]  = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h08070605, 1'b1, 3'd2, 16'd1};
    tbl[10] = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0D0C0B0A, 1'b0, 3'd1, 16'd2};
    tbl[11] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 16'd2};

    @(posedge clk);
    #1;
    started = 1'b1;

    // Reset values and cycle-by-cycle table.
    do_reset();
    check("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_data", m_axis_tdata, 32'd0);
    check("rst_m_last", 32'(m_axis_tlast), 32'd0);
    for (int i = 0; i < 12; i++) begin
      s_axis_tvalid = tbl[i].v;
      s_axis_tdata  = tbl[i].d;
      s_axis_tlast  = tbl[i].l;
      m_axis_tready = tbl[i].mr;
      #2;
      check($sformatf("tbl%0d_s_ready", i), 32'(s_axis_tready), 32'(tbl[i].e_sr));
      check($sformatf("tbl%0d_m_valid", i), 32'(m_axis_tvalid), 32'(tbl[i].e_mv));
      if (tbl[i].e_mv) begin
        check($sformatf("tbl%0d_m_data", i), m_axis_tdata, tbl[i].e_md);
        check($sformatf("tbl%0d_m_last", i), 32'(m_axis_tlast), 32'(tbl[i].e_ml));
      end
      check($sformatf("tbl%0d_occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
      check($sformatf("tbl%0d_pkt", i), 32'(pkt_count), 32'(tbl[i].e_pkt));
      @(posedge clk);
      #1;
    end

    // Full-throughput stream 0..99: latency STAGES, no gaps, occupancy steady at STAGES.
    do_reset();
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    check("stream_ready_low", 32'(s_axis_tready), 32'd0);
    for (int i = 0; i < 100; i++) begin
      if (i == 1) check("stream_latency_early", 32'(m_axis_tvalid), 32'd0);
      if (i >= 2) begin
        check("stream_no_gap", 32'(m_axis_tvalid), 32'd1);
        check("stream_occ", 32'(occupancy), 32'(STAGES));
      end
      send_beat(32'(i), (i % 4) == 3);
    end
    drain();

    // Backpressure from the start: exactly 2*STAGES beats absorbed, then release.
    do_reset();
    s_axis_tvalid = 1'b1;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      s_axis_tdata = 32'h100 + 32'(acc);
      s_axis_tlast = acc[0];
      if (s_axis_tready) acc++;
      @(posedge clk);
      #1;
    end
    check("bp_accepted", 32'(acc), 32'(2 * STAGES));
    check("bp_ready_low", 32'(s_axis_tready), 32'd0);
    check("bp_occ_full", 32'(occupancy), 32'(2 * STAGES));
    m_axis_tready = 1'b1;
    waited = 0;
    while (!s_axis_tready && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("bp_release_bound", 32'(waited >= 1 && waited <= int'(STAGES)), 32'd1);
    for (int i = 0; i < 6; i++) send_beat(32'h100 + 32'(acc + i), 1'b1);
    drain();

    // Reset while full: held beats discarded, counters cleared.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(32'hDEAD0000 + 32'(i), 1'b1);
    s_axis_tvalid = 1'b0;
    check("full_occ", 32'(occupancy), 32'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_m_valid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_occ", 32'(occupancy), 32'd0);
    check("midrst_pkt", 32'(pkt_count), 32'd0);
    check("midrst_s_ready", 32'(s_axis_tready), 32'd0);
    m_axis_tready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_output", 32'(m_axis_tvalid), 32'd0);

    // Random valid/ready; source holds each beat until accepted.
    sent = 0;
    s_axis_tvalid = 1'b0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      acc_now = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
      if (acc_now) sent++;
      if (!s_axis_tvalid || acc_now) begin
        s_axis_tvalid = ($urandom_range(0, 1) == 1) && (sent < 1000);
        s_axis_tdata  = $urandom;
        s_axis_tlast  = 1'($urandom_range(0, 1));
      end
      m_axis_tready = 1'($urandom_range(0, 1));
    end
    check("random_sent", 32'(sent), 32'd1000);
    drain();

    // pkt_count wrap: 65535 single-beat packets, then one more.
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 65535; i++) send_beat(32'(i), 1'b1);
    drain();
    check("pkt_near_wrap", 32'(pkt_count), 32'h0000FFFF);
    send_beat(32'h12345678, 1'b1);
    drain();
    check("pkt_wrapped", 32'(pkt_count), 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
